// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD accumulator calculator.
// The CORRIGE state exists only when CALC_RESTA_EN is defined.
package calc_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

`ifdef CALC_RESTA_EN
   typedef enum logic [1:0] {
      ENTRADA   = 2'd0,
      SUMA      = 2'd1,
      CORRIGE   = 2'd2,
      RESULTADO = 2'd3
   } calc_estado_t;
`else
   typedef enum logic [1:0] {
      ENTRADA   = 2'd0,
      SUMA      = 2'd1,
      RESULTADO = 2'd3
   } calc_estado_t;
`endif

   function automatic bcd_t nueve_comp(bcd_t d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/calc_bcd_acumulador_adder.sv
// One-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_adder
   import calc_pkg::*;
(
   input  bcd_t a,
   input  bcd_t b,
   input  logic cin,
   output bcd_t s,
   output logic cout
);

   logic [4:0] bin;
   logic [4:0] adj;

   assign bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign adj  = bin + 5'd6;
   assign cout = (bin > 5'd9);
   assign s    = cout ? adj[3:0] : bin[3:0];

endmodule

// File: rtl/calc_bcd_acumulador.sv
// Keypad entry, digit-serial BCD accumulator and result presentation.
// Optional ten's-complement subtraction is enabled by defining CALC_RESTA_EN.
module calc_bcd_acumulador
   import calc_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [3:0]            entrada,
   input  logic                  guardar,
   input  logic                  finalizar,
`ifdef CALC_RESTA_EN
   input  logic                  resta,
`endif
   output logic [4*DIGITS-1:0]   numero,
   output logic [4*DIGITS-1:0]   resultado,
   output logic                  mostrar_res,
   output logic                  ocupado,
   output logic                  desborde,
   output logic                  negativo,
   output logic                  error_dig
);

   localparam int AW = DIGIT_W * (DIGITS + 1);
   localparam int NW = DIGIT_W * DIGITS;
   localparam int IW = $clog2(DIGITS + 1);
   localparam logic [IW-1:0] ULTIMO = IW'(DIGITS);

   calc_estado_t    estado_reg;
   logic [NW-1:0]   numero_reg;
   logic [NW-1:0]   res_reg;
   logic [AW-1:0]   acc_reg;
   logic [IW-1:0]   cuenta_reg;
   logic [IW-1:0]   idx_reg;
   logic            carry_reg;
   logic            final_reg;
   logic            mostrar_reg;
   logic            desborde_reg;
   logic            error_reg;

   bcd_t sum_a, sum_b, sum_s;
   logic sum_cin, sum_cout;
   logic digito_ok, lleno, desborde_det, bajos_cero;

`ifdef CALC_RESTA_EN
   logic            resta_reg;
   logic            negativo_reg;
   logic [NW-1:0]   corr_reg;
`endif

   // acc and numero rotate one digit per cycle, so the adder always sees digit 0.
   always_comb begin
      sum_a   = acc_reg[DIGIT_W-1:0];
      sum_b   = numero_reg[DIGIT_W-1:0];
      sum_cin = (idx_reg == '0) ? 1'b0 : carry_reg;
`ifdef CALC_RESTA_EN
      if (estado_reg == CORRIGE) begin
         sum_a   = '0;
         sum_b   = nueve_comp(acc_reg[DIGIT_W-1:0]);
         sum_cin = (idx_reg == '0) ? 1'b1 : carry_reg;
      end else if (resta_reg) begin
         sum_b   = nueve_comp(numero_reg[DIGIT_W-1:0]);
         sum_cin = (idx_reg == '0) ? 1'b1 : carry_reg;
      end
`endif
   end

   bcd_digit_adder u_adder (
      .a    (sum_a),
      .b    (sum_b),
      .cin  (sum_cin),
      .s    (sum_s),
      .cout (sum_cout)
   );

   assign digito_ok  = (entrada <= BCD_MAX);
   assign lleno      = (cuenta_reg == ULTIMO);
   assign bajos_cero = (acc_reg[AW-1:DIGIT_W] == '0);

`ifdef CALC_RESTA_EN
   assign desborde_det = ((sum_s != '0) && (sum_s != BCD_MAX)) ||
                         ((sum_s == BCD_MAX) && bajos_cero);
`else
   assign desborde_det = (sum_s != '0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_reg   <= ENTRADA;
         numero_reg   <= '0;
         res_reg      <= '0;
         acc_reg      <= '0;
         cuenta_reg   <= '0;
         idx_reg      <= '0;
         carry_reg    <= 1'b0;
         final_reg    <= 1'b0;
         mostrar_reg  <= 1'b0;
         desborde_reg <= 1'b0;
         error_reg    <= 1'b0;
`ifdef CALC_RESTA_EN
         resta_reg    <= 1'b0;
         negativo_reg <= 1'b0;
         corr_reg     <= '0;
`endif
      end else begin
         error_reg <= 1'b0;
         case (estado_reg)
            ENTRADA: begin
               if (finalizar || guardar) begin
                  final_reg  <= finalizar;
                  idx_reg    <= '0;
                  estado_reg <= SUMA;
`ifdef CALC_RESTA_EN
                  resta_reg  <= resta;
`endif
               end else if (push) begin
                  if (!digito_ok) begin
                     error_reg <= 1'b1;
                  end else if (!lleno) begin
                     numero_reg <= {numero_reg[NW-DIGIT_W-1:0], entrada};
                     cuenta_reg <= cuenta_reg + IW'(1);
                  end
               end
            end
            SUMA: begin
               acc_reg    <= {sum_s, acc_reg[AW-1:DIGIT_W]};
               numero_reg <= numero_reg >> DIGIT_W;
               carry_reg  <= sum_cout;
               idx_reg    <= idx_reg + IW'(1);
               if (idx_reg == ULTIMO) begin
                  cuenta_reg <= '0;
                  if (desborde_det)
                     desborde_reg <= 1'b1;
                  if (!final_reg) begin
                     estado_reg <= ENTRADA;
                  end else begin
`ifdef CALC_RESTA_EN
                     if (sum_s == BCD_MAX) begin
                        estado_reg <= CORRIGE;
                        idx_reg    <= '0;
                     end else begin
                        estado_reg   <= RESULTADO;
                        mostrar_reg  <= 1'b1;
                        res_reg      <= acc_reg[AW-1:DIGIT_W];
                        negativo_reg <= 1'b0;
                     end
`else
                     estado_reg  <= RESULTADO;
                     mostrar_reg <= 1'b1;
                     res_reg     <= acc_reg[AW-1:DIGIT_W];
`endif
                  end
               end
            end
`ifdef CALC_RESTA_EN
            // Negate acc into corr_reg; acc rotates back unchanged so chaining continues.
            CORRIGE: begin
               acc_reg   <= {acc_reg[DIGIT_W-1:0], acc_reg[AW-1:DIGIT_W]};
               carry_reg <= sum_cout;
               idx_reg   <= idx_reg + IW'(1);
               if (idx_reg != ULTIMO) begin
                  corr_reg <= {sum_s, corr_reg[NW-1:DIGIT_W]};
               end else begin
                  estado_reg   <= RESULTADO;
                  mostrar_reg  <= 1'b1;
                  res_reg      <= corr_reg;
                  negativo_reg <= 1'b1;
               end
            end
`endif
            RESULTADO: begin
               if (finalizar) begin
                  estado_reg <= RESULTADO;
               end else if (guardar) begin
                  mostrar_reg <= 1'b0;
                  estado_reg  <= ENTRADA;
               end else if (push) begin
                  if (!digito_ok) begin
                     error_reg <= 1'b1;
                  end else begin
                     acc_reg      <= '0;
                     desborde_reg <= 1'b0;
                     numero_reg   <= {{(NW-DIGIT_W){1'b0}}, entrada};
                     cuenta_reg   <= IW'(1);
                     mostrar_reg  <= 1'b0;
                     estado_reg   <= ENTRADA;
`ifdef CALC_RESTA_EN
                     negativo_reg <= 1'b0;
`endif
                  end
               end
            end
            default: estado_reg <= ENTRADA;
         endcase
      end
   end

   assign numero      = numero_reg;
   assign resultado   = res_reg;
   assign mostrar_res = mostrar_reg;
   assign desborde    = desborde_reg;
   assign error_dig   = error_reg;

`ifdef CALC_RESTA_EN
   assign ocupado  = (estado_reg == SUMA) || (estado_reg == CORRIGE);
   assign negativo = negativo_reg;
`else
   assign ocupado  = (estado_reg == SUMA);
   assign negativo = 1'b0;
`endif

endmodule

// File: tb/tb_calc_bcd_acumulador.sv
// Self-checking bench for calc_bcd_acumulador (DIGITS=4), directed plus random chains
// against a plain-integer model. The subtraction scenario runs only with CALC_RESTA_EN.
module tb_calc_bcd_acumulador;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push = 1'b0;
   logic [3:0]  entrada = 4'd0;
   logic        guardar = 1'b0;
   logic        finalizar = 1'b0;
   logic        resta = 1'b0;
   logic [15:0] numero;
   logic [15:0] resultado;
   logic        mostrar_res;
   logic        ocupado;
   logic        desborde;
   logic        negativo;
   logic        error_dig;

   int tests = 0;
   int fails = 0;

   // plain-integer reference state
   int  acc_m = 0;
   bit  desb_m = 1'b0;
   bit  en_res_m = 1'b0;

   calc_bcd_acumulador #(.DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .entrada     (entrada),
      .guardar     (guardar),
      .finalizar   (finalizar),
`ifdef CALC_RESTA_EN
      .resta       (resta),
`endif
      .numero      (numero),
      .resultado   (resultado),
      .mostrar_res (mostrar_res),
      .ocupado     (ocupado),
      .desborde    (desborde),
      .negativo    (negativo),
      .error_dig   (error_dig)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic push_key(input int d);
      @(negedge clk);
      push = 1'b1;
      entrada = 4'(d);
      @(negedge clk);
      push = 1'b0;
   endtask

   task automatic enter_number(input int v);
      int p;
      p = 1000;
      for (int i = 0; i < 4; i++) begin
         push_key((v / p) % 10);
         p = p / 10;
      end
   endtask

   // Pulses guardar or finalizar, returns the number of cycles ocupado stayed high.
   task automatic do_op(input bit fin, input bit sub, output int busy);
      @(negedge clk);
      if (fin) finalizar = 1'b1; else guardar = 1'b1;
      resta = sub;
      @(negedge clk);
      finalizar = 1'b0;
      guardar = 1'b0;
      resta = 1'b0;
      busy = 0;
      while (ocupado === 1'b1 && busy < 40) begin
         busy++;
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      acc_m = 0;
      desb_m = 1'b0;
      en_res_m = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({numero, resultado, mostrar_res, ocupado, desborde, negativo, error_dig} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got numero=%h resultado=%h mr=%b oc=%b de=%b ng=%b er=%b, want all 0",
                  numero, resultado, mostrar_res, ocupado, desborde, negativo, error_dig);
      end
      rst = 1'b1;
      @(negedge clk);
      enter_number(1234);
      tests++;
      if (numero !== 16'h1234) begin
         fails++;
         $display("FAIL entry_1234: got %h want 1234", numero);
      end
      $display("[TB] entry 1234 -> numero=%h", numero);
   endtask

   task automatic test_limits();
      push_key(7);
      tests++;
      if (numero !== 16'h1234) begin
         fails++;
         $display("FAIL fifth_push_ignored: got %h want 1234", numero);
      end
      push_key(10);
      tests++;
      if (error_dig !== 1'b1) begin
         fails++;
         $display("FAIL error_dig_pulse: got %b want 1", error_dig);
      end
      @(negedge clk);
      tests++;
      if (error_dig !== 1'b0) begin
         fails++;
         $display("FAIL error_dig_width: got %b want 0", error_dig);
      end
      tests++;
      if (numero !== 16'h1234) begin
         fails++;
         $display("FAIL invalid_key_numero: got %h want 1234", numero);
      end
      $display("[TB] limits: fifth push and key 0xA checked");
   endtask

   task automatic test_add();
      int busy;
      do_op(1'b0, 1'b0, busy);
      tests++;
      if (busy !== 5 || mostrar_res !== 1'b0 || numero !== 16'h0000) begin
         fails++;
         $display("FAIL guardar_1234: busy=%0d mr=%b numero=%h, want busy=5 mr=0 numero=0000",
                  busy, mostrar_res, numero);
      end
      enter_number(5678);
      do_op(1'b1, 1'b0, busy);
      tests++;
      if (busy !== 5) begin
         fails++;
         $display("FAIL busy_add: got %0d want 5", busy);
      end
      tests++;
      if (resultado !== 16'h6912 || mostrar_res !== 1'b1 || desborde !== 1'b0) begin
         fails++;
         $display("FAIL sum_6912: got res=%h mr=%b de=%b want res=6912 mr=1 de=0",
                  resultado, mostrar_res, desborde);
      end
      $display("[TB] 1234 + 5678 -> resultado=%h", resultado);
   endtask

   task automatic test_overflow();
      int busy;
      enter_number(9999);
      do_op(1'b0, 1'b0, busy);
      enter_number(1);
      do_op(1'b1, 1'b0, busy);
      tests++;
      if (resultado !== 16'h0000 || desborde !== 1'b1 || mostrar_res !== 1'b1) begin
         fails++;
         $display("FAIL overflow_9999_1: got res=%h de=%b mr=%b want res=0000 de=1 mr=1",
                  resultado, desborde, mostrar_res);
      end
      push_key(3);
      tests++;
      if (desborde !== 1'b0 || numero !== 16'h0003 || mostrar_res !== 1'b0) begin
         fails++;
         $display("FAIL new_calc_push3: got de=%b numero=%h mr=%b want de=0 numero=0003 mr=0",
                  desborde, numero, mostrar_res);
      end
      do_op(1'b0, 1'b0, busy);
      enter_number(9999);
      do_op(1'b1, 1'b0, busy);
      tests++;
      if (resultado !== 16'h0002 || desborde !== 1'b1) begin
         fails++;
         $display("FAIL overflow_3_9999: got res=%h de=%b want res=0002 de=1", resultado, desborde);
      end
      $display("[TB] overflow chains -> resultado=%h desborde=%b", resultado, desborde);
   endtask

   task automatic test_reset_mid_suma();
      int busy;
      do_op(1'b0, 1'b0, busy);
      push_key(1);
      @(negedge clk);
      guardar = 1'b1;
      @(negedge clk);
      guardar = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (ocupado !== 1'b1) begin
         fails++;
         $display("FAIL mid_suma_busy: got %b want 1", ocupado);
      end
      rst = 1'b0;
      #1;
      tests++;
      if ({ocupado, numero, resultado, desborde, mostrar_res, negativo} !== '0) begin
         fails++;
         $display("FAIL async_reset: got oc=%b numero=%h res=%h de=%b mr=%b ng=%b want all 0",
                  ocupado, numero, resultado, desborde, mostrar_res, negativo);
      end
      @(negedge clk);
      rst = 1'b1;
      push_key(8);
      tests++;
      if (numero !== 16'h0008) begin
         fails++;
         $display("FAIL after_reset_push8: got %h want 0008", numero);
      end
      $display("[TB] reset in SUMA, then push 8 -> numero=%h", numero);
      apply_reset();
   endtask

   task automatic test_random();
      int busy, n_ops, v;
      for (int t = 0; t < 20; t++) begin
         n_ops = $urandom_range(1, 3);
         for (int k = 0; k < n_ops; k++) begin
            v = (($urandom % 4) == 0) ? $urandom_range(9000, 9999) : $urandom_range(0, 9999);
            if (en_res_m) begin
               acc_m = 0;
               desb_m = 1'b0;
               en_res_m = 1'b0;
            end
            enter_number(v);
            tests++;
            if (numero !== to_bcd(v)) begin
               fails++;
               $display("FAIL rand_entry: got %h want %h", numero, to_bcd(v));
            end
            acc_m = (acc_m + v) % 100000;
            if (acc_m >= 10000) desb_m = 1'b1;
            do_op(k == n_ops - 1, 1'b0, busy);
            tests++;
            if (busy !== 5) begin
               fails++;
               $display("FAIL rand_busy: got %0d want 5", busy);
            end
         end
         en_res_m = 1'b1;
         tests++;
         if (resultado !== to_bcd(acc_m % 10000) || desborde !== desb_m ||
             mostrar_res !== 1'b1 || negativo !== 1'b0) begin
            fails++;
            $display("FAIL rand_result: got res=%h de=%b mr=%b ng=%b want res=%h de=%b mr=1 ng=0",
                     resultado, desborde, mostrar_res, negativo, to_bcd(acc_m % 10000), desb_m);
         end
         $display("[TB] chain %0d: %0d ops -> resultado=%h desborde=%b", t, n_ops, resultado, desborde);
         // Occasionally continue the running total instead of starting over.
         if (($urandom % 3) == 0 && acc_m < 30000) begin
            do_op(1'b0, 1'b0, busy);
            en_res_m = 1'b0;
            tests++;
            if (mostrar_res !== 1'b0 || ocupado !== 1'b0) begin
               fails++;
               $display("FAIL rand_continue: got mr=%b oc=%b want 0 0", mostrar_res, ocupado);
            end
         end
      end
   endtask

`ifdef CALC_RESTA_EN
   task automatic test_resta();
      int busy;
      apply_reset();
      enter_number(25);
      do_op(1'b0, 1'b0, busy);
      enter_number(100);
      do_op(1'b1, 1'b1, busy);
      tests++;
      if (busy !== 10) begin
         fails++;
         $display("FAIL resta_busy: got %0d want 10", busy);
      end
      tests++;
      if (resultado !== 16'h0075 || negativo !== 1'b1 || desborde !== 1'b0) begin
         fails++;
         $display("FAIL resta_25_100: got res=%h ng=%b de=%b want res=0075 ng=1 de=0",
                  resultado, negativo, desborde);
      end
      $display("[TB] 25 - 100 -> resultado=%h negativo=%b", resultado, negativo);
   endtask
`endif

   initial begin
      test_reset();
      test_limits();
      test_add();
      test_overflow();
      test_reset_mid_suma();
      test_random();
`ifdef CALC_RESTA_EN
      test_resta();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
